// File: rtl/de0qsys_button_irq_ctrl_if.sv
// Avalon-MM master bus between the button IRQ controller and the PIO cores.
// The controller drives it through the master modport; PIO-side logic uses slave.
interface de0qsys_button_irq_ctrl_if;
    logic [5:0]  m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_waitrequest;

    modport master (
        output m_address,
        output m_read,
        output m_write,
        output m_writedata,
        input  m_readdata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_read,
        input  m_write,
        input  m_writedata,
        output m_readdata,
        output m_waitrequest
    );
endinterface

// File: rtl/de0qsys_button_irq_ctrl.sv
// Services button PIO interrupts: reads/clears edge capture per channel and
// queues channel ids in a FIFO that the CPU drains through a small slave port.
module de0qsys_button_irq_ctrl #(
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCH-1:0]            irq_in,
    de0qsys_button_irq_ctrl_if.master avm,
    input  logic [1:0]                address,
    input  logic                      chipselect,
    input  logic                      read_n,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EC   = 2'd3;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_EC,
        CLR_EC,
        PUSH
    } state_t;

    state_t state;
    state_t state_nx;

    logic          started;
    logic [1:0]    init_ch;
    logic [1:0]    cur_ch;
    logic [1:0]    rr_ptr;
    logic [1:0]    sel_ch;
    logic          sel_vld;
    logic [NCH-1:0] req;
    logic          done;

    logic [3:0]    en_mask;
    logic          cpu_irq_en;
    logic          reinit;
    logic [7:0]    ovf;

    logic [1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          nonempty;
    logic          full;
    logic [1:0]    head;

    logic          rd_stb;
    logic          wr_stb;
    logic          pop;
    logic          push;
    logic          drop;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign done     = ~avm.m_waitrequest;
    assign req      = irq_in & en_mask;
    assign nonempty = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign head     = fifo_mem[rd_ptr];

    assign rd_stb = chipselect & ~read_n;
    assign wr_stb = chipselect & ~write_n;
    assign pop    = rd_stb & (address == 2'd0) & nonempty;
    assign push   = (state == PUSH) & (~full | pop);
    assign drop   = (state == PUSH) & full & ~pop;

    assign irq = cpu_irq_en & nonempty;

    assign unused_bits = ^{writedata[31:9], writedata[7:4],
                           avm.m_readdata[31:1]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the farthest candidate to the nearest so the channel just
    // above the last grant wins; the last-granted channel is lowest priority.
    always_comb begin
        logic [1:0] cand;
        cand    = rr_ptr;
        sel_vld = 1'b0;
        sel_ch  = rr_ptr;
        for (int i = NCH; i >= 1; i--) begin
            cand = rr_ptr + 2'(i);
            if (req[cand]) begin
                sel_vld = 1'b1;
                sel_ch  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT: begin
                if (started && done && init_ch == 2'd3)
                    state_nx = IDLE;
            end
            IDLE: begin
                if (reinit)
                    state_nx = INIT;
                else if (sel_vld)
                    state_nx = RD_EC;
            end
            RD_EC: begin
                if (done)
                    state_nx = avm.m_readdata[0] ? CLR_EC : IDLE;
            end
            CLR_EC: begin
                if (done)
                    state_nx = PUSH;
            end
            PUSH:    state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    // Strobes are held off for the first cycle after reset release so that
    // they drop together with reset_n rather than glitching during it.
    always_comb begin
        avm.m_read      = 1'b0;
        avm.m_write     = 1'b0;
        avm.m_address   = {init_ch, REG_MASK, 2'b00};
        avm.m_writedata = '0;
        unique case (state)
            INIT: begin
                avm.m_write     = started;
                avm.m_address   = {init_ch, REG_MASK, 2'b00};
                avm.m_writedata = {31'b0, en_mask[init_ch]};
            end
            RD_EC: begin
                avm.m_read    = 1'b1;
                avm.m_address = {cur_ch, REG_EC, 2'b00};
            end
            CLR_EC: begin
                avm.m_write   = 1'b1;
                avm.m_address = {cur_ch, REG_EC, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_ch <= 2'd0;
            cur_ch  <= 2'd0;
            rr_ptr  <= 2'd3;
        end else begin
            if (state == INIT && started && done)
                init_ch <= init_ch + 2'd1;
            if (state == IDLE && !reinit && sel_vld) begin
                cur_ch <= sel_ch;
                rr_ptr <= sel_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_mask    <= 4'hF;
            cpu_irq_en <= 1'b0;
            reinit     <= 1'b0;
        end else if (wr_stb && address == 2'd2) begin
            en_mask    <= writedata[3:0];
            cpu_irq_en <= writedata[8];
            reinit     <= 1'b1;
        end else if (state == IDLE && reinit) begin
            reinit     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf <= 8'd0;
        else if (wr_stb && address == 2'd3)
            ovf <= 8'd0;
        else if (drop && ovf != 8'hFF)
            ovf <= ovf + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= cur_ch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (address)
            2'd0: rd_mux = nonempty ? {1'b1, 29'b0, head} : 32'd0;
            2'd1: rd_mux = {16'b0, ovf, 4'b0, 4'(count)};
            2'd2: rd_mux = {23'b0, cpu_irq_en, 4'b0, en_mask};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else if (rd_stb)
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_de0qsys_button_irq_ctrl.sv
// Bench for the button IRQ controller: PIO slave model on the master bus,
// expected bus transactions and FIFO contents tracked as scoreboards.
module tb_de0qsys_button_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  irq_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    de0qsys_button_irq_ctrl_if bus ();

    de0qsys_button_irq_ctrl #(.NCH(4), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .avm        (bus.master),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    int n_chk = 0;
    int n_err = 0;

    txn_t       exp_q [$];
    int         exp_rd = 0;
    logic [1:0] clr_q [$];
    int         clr_rd = 0;
    int         clr_cnt = 0;
    logic [1:0] fifo_m [$];
    int         ovf_m = 0;

    int   press_cnt [4];
    int   spur_cnt [4];
    int   clr_ack [4] = '{0, 0, 0, 0};
    int   spur_ack [4] = '{0, 0, 0, 0};
    logic [3:0] pio_mask = 4'h0;
    logic [3:0] hold_force;
    logic       hold_wait;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always_comb begin
        irq_in = '0;
        for (int i = 0; i < 4; i++)
            irq_in[i] = ((press_cnt[i] != clr_ack[i]) & pio_mask[i])
                      | (spur_cnt[i] != spur_ack[i]) | hold_force[i];
    end

    assign bus.m_readdata = {31'b0,
        press_cnt[bus.m_address[5:4]] != clr_ack[bus.m_address[5:4]]};

    initial begin
        bus.m_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_waitrequest = hold_wait ? 1'b1
                                          : ($urandom_range(0, 3) == 0);
        end
    end

    logic        prev_stall = 1'b0;
    logic [5:0]  prev_addr;
    logic [1:0]  prev_stb;
    logic [31:0] prev_data;
    txn_t        mon_e;
    logic [1:0]  mon_ch;

    // PIO slave model and transaction checker, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_addr", {26'b0, bus.m_address}, {26'b0, prev_addr});
                chk("hold_stb", {30'b0, bus.m_read, bus.m_write},
                    {30'b0, prev_stb});
                if (prev_stb[0])
                    chk("hold_data", bus.m_writedata, prev_data);
            end
            prev_stall = (bus.m_read | bus.m_write) & bus.m_waitrequest;
            prev_addr  = bus.m_address;
            prev_stb   = {bus.m_read, bus.m_write};
            prev_data  = bus.m_writedata;
            if ((bus.m_read | bus.m_write) & ~bus.m_waitrequest) begin
                mon_ch = bus.m_address[5:4];
                if (exp_rd >= exp_q.size()) begin
                    chk("txn_extra", exp_q.size() - exp_rd, 1);
                end else begin
                    mon_e = exp_q[exp_rd];
                    exp_rd++;
                    chk("txn_wr", {31'b0, bus.m_write}, {31'b0, mon_e.wr});
                    chk("txn_addr", {26'b0, bus.m_address},
                        {26'b0, mon_e.addr});
                    if (mon_e.wr)
                        chk("txn_data", bus.m_writedata, mon_e.data);
                end
                if (bus.m_write && bus.m_address[3:2] == 2'd2)
                    pio_mask[mon_ch] = bus.m_writedata[0];
                if (bus.m_write && bus.m_address[3:2] == 2'd3) begin
                    clr_ack[mon_ch] = press_cnt[mon_ch];
                    clr_q.push_back(mon_ch);
                    clr_cnt++;
                end
                if (bus.m_read && bus.m_readdata[0] == 1'b0)
                    spur_ack[mon_ch] = spur_cnt[mon_ch];
            end
        end
    end

    task automatic exp_txn(input logic wr, input logic [5:0] a,
                           input logic [31:0] d);
        txn_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_init(input logic [3:0] m);
        for (int c = 0; c < 4; c++)
            exp_txn(1'b1, {2'(c), 4'b1000}, {31'b0, m[c]});
    endtask

    task automatic exp_event(input logic [1:0] c);
        exp_txn(1'b0, {c, 4'b1100}, 32'd0);
        exp_txn(1'b1, {c, 4'b1100}, 32'd0);
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (exp_rd < exp_q.size() && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size() - exp_rd, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic absorb();
        while (clr_rd < clr_q.size()) begin
            if (fifo_m.size() < 8)
                fifo_m.push_back(clr_q[clr_rd]);
            else if (ovf_m < 255)
                ovf_m++;
            clr_rd++;
        end
    endtask

    function automatic logic [31:0] stat_word();
        return {16'b0, 8'(ovf_m), 4'b0, 4'(fifo_m.size())};
    endfunction

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        read_n = 1'b0;
        address = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n = 1'b1;
        d = readdata;
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        write_n = 1'b0;
        address = a;
        writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        cpu_rd(2'd0, d);
        if (fifo_m.size() == 0) begin
            chk(tag, d, 32'd0);
        end else begin
            chk(tag, d, {1'b1, 29'b0, fifo_m[0]});
            void'(fifo_m.pop_front());
        end
    endtask

    initial begin
        logic [31:0] d;
        int t;
        int c0;
        chipselect = 1'b0;
        read_n = 1'b1;
        write_n = 1'b1;
        address = 2'd0;
        writedata = '0;
        hold_wait = 1'b0;
        hold_force = 4'h0;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            spur_cnt[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_read", {31'b0, bus.m_read}, 32'd0);
        chk("rst_m_write", {31'b0, bus.m_write}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);

        exp_init(4'hF);
        reset_n = 1'b1;
        drain(200);
        cpu_rd(2'd1, d);
        chk("stat_idle", d, 32'd0);
        cpu_rd(2'd2, d);
        chk("mask_rst", d, 32'h0000_000F);

        for (int r = 0; r < 2; r++) begin
            press_cnt[0]++;
            press_cnt[2]++;
            exp_event(2'd0);
            exp_event(2'd2);
            drain(300);
            absorb();
        end
        cpu_rd(2'd1, d);
        chk("stat_rr", d, stat_word());
        for (int i = 0; i < 4; i++)
            pop_check("pop_rr");
        pop_check("pop_empty");

        for (int i = 0; i < 9; i++) begin
            press_cnt[i % 4]++;
            exp_event(2'(i % 4));
            drain(300);
            absorb();
        end
        cpu_rd(2'd1, d);
        chk("stat_ovf", d, stat_word());
        chk("stat_ovf_word", d, 32'h0000_0108);

        // pop lands in the same cycle as the controller's PUSH state
        press_cnt[1]++;
        exp_event(2'd1);
        c0 = clr_cnt;
        t = 0;
        while (clr_cnt == c0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("full_wait", clr_cnt - c0, 1);
        #1;
        chipselect = 1'b1;
        read_n = 1'b0;
        address = 2'd0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n = 1'b1;
        chk("full_pop", readdata, {1'b1, 29'b0, fifo_m[0]});
        void'(fifo_m.pop_front());
        absorb();
        drain(100);
        cpu_rd(2'd1, d);
        chk("stat_full_pp", d, stat_word());

        cpu_wr(2'd3, 32'h1234_5678);
        ovf_m = 0;
        cpu_rd(2'd1, d);
        chk("stat_ovf_clr", d, stat_word());
        for (int i = 0; i < 8; i++)
            pop_check("pop_drain");
        pop_check("pop_empty2");

        spur_cnt[3]++;
        exp_txn(1'b0, 6'h3C, 32'd0);
        drain(200);
        repeat (10) @(posedge clk);
        absorb();
        cpu_rd(2'd1, d);
        chk("stat_spur", d, stat_word());

        exp_init(4'h5);
        cpu_wr(2'd2, 32'h0000_0105);
        drain(200);
        cpu_rd(2'd2, d);
        chk("mask_rd", d, 32'h0000_0105);
        hold_force[1] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("irq_masked", {31'b0, irq}, 32'd0);
        press_cnt[2]++;
        exp_event(2'd2);
        drain(300);
        absorb();
        chk("irq_on", {31'b0, irq}, 32'd1);
        pop_check("pop_irq");
        #1;
        chk("irq_off", {31'b0, irq}, 32'd0);
        hold_force[1] = 1'b0;

        hold_wait = 1'b1;
        repeat (2) @(posedge clk);
        press_cnt[0]++;
        t = 0;
        while (!bus.m_read && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("stall_read", {31'b0, bus.m_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_read", {31'b0, bus.m_read}, 32'd0);
        chk("rst_mid_write", {31'b0, bus.m_write}, 32'd0);
        chk("rst_mid_irq", {31'b0, irq}, 32'd0);
        fifo_m.delete();
        ovf_m = 0;
        hold_wait = 1'b0;
        exp_init(4'hF);
        exp_event(2'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drain(300);
        absorb();
        cpu_rd(2'd1, d);
        chk("stat_rerun", d, stat_word());
        cpu_rd(2'd2, d);
        chk("mask_rerun", d, 32'h0000_000F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
